// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the ALU arbiter: bus widths, ALU opcode encodings, abort codes
// and the arbiter state encoding.
package alu_arbiter_pkg;

  localparam int REG_BUS   = 32;
  localparam int BIT_WIDTH = REG_BUS;
  localparam int ALUC_BUS  = 4;

  localparam logic [ALUC_BUS-1:0] ALUC_ADD      = 4'h1;
  localparam logic [ALUC_BUS-1:0] ALUC_SUB      = 4'h2;
  localparam logic [ALUC_BUS-1:0] ALUC_ADD_JALR = 4'h3;

  localparam int unsigned ABORT    = 32'd1;
  localparam int unsigned UNIT_ALU = 32'd2;

  typedef enum logic {
    ALU_ARB_IDLE = 1'b0,
    ALU_ARB_RESP = 1'b1
  } arb_state_e;

endpackage

// File: rtl/alu_arbiter_op_eval.sv
// Combinational RV32E ALU slice: ADD, SUB and ADD_JALR. Any other opcode yields
// zero with the illegal flag raised.
module alu_op_eval
  import alu_arbiter_pkg::*;
#(
  parameter int BitWidth  = BIT_WIDTH,
  parameter int AlucWidth = ALUC_BUS
) (
  input  logic [AlucWidth-1:0] i_aluc,
  input  logic [BitWidth-1:0]  i_num1,
  input  logic [BitWidth-1:0]  i_num2,
  output logic [BitWidth-1:0]  o_result,
  output logic                 o_illegal
);

  logic [BitWidth-1:0] w_sum;
  logic [BitWidth-1:0] w_diff;

  assign w_sum  = i_num1 + i_num2;
  assign w_diff = i_num1 - i_num2;

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    o_result  = '0;
    o_illegal = 1'b0;
    case (i_aluc)
      AlucWidth'(ALUC_ADD):      o_result = w_sum;
      AlucWidth'(ALUC_SUB):      o_result = w_diff;
      AlucWidth'(ALUC_ADD_JALR): o_result = {w_sum[BitWidth-1:1], 1'b0};
      default:                   o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between EXU (port 0) and LSU (port 1), with a
// single registered result. Optional macro ALU_ARB_ABORT_EN halts simulation on illegal opcodes.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int BitWidth  = BIT_WIDTH,
  parameter int AlucWidth = ALUC_BUS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [AlucWidth-1:0] req_aluc0,
  input  logic [AlucWidth-1:0] req_aluc1,
  input  logic [BitWidth-1:0]  req_num1_0,
  input  logic [BitWidth-1:0]  req_num2_0,
  input  logic [BitWidth-1:0]  req_num1_1,
  input  logic [BitWidth-1:0]  req_num2_1,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [BitWidth-1:0]  rsp_result,
  output logic                 rsp_err
);

  arb_state_e          r_state;
  logic                r_prio;
  logic                r_own;
  logic [BitWidth-1:0] r_result;
  logic                r_err;

  logic [1:0]           w_grant;
  logic                 w_sel;
  logic                 w_can_accept;
  logic                 w_accept;
  logic                 w_rsp_hs;
  logic [AlucWidth-1:0] w_aluc;
  logic [BitWidth-1:0]  w_num1;
  logic [BitWidth-1:0]  w_num2;
  logic [BitWidth-1:0]  w_eval_result;
  logic                 w_eval_illegal;

  // Contention is resolved by prio; a lone requester wins outright.
  assign w_grant = (&req_valid) ? (r_prio ? 2'b10 : 2'b01) : req_valid;
  assign w_sel   = w_grant[1];

  // A new request may enter when nothing is held, or when the held result leaves this cycle.
  assign w_can_accept = (r_state == ALU_ARB_IDLE) || rsp_ready[r_own];
  assign req_ready    = w_grant & {2{w_can_accept}};

  assign w_accept = |(req_valid & req_ready);
  assign w_rsp_hs = |(rsp_valid & rsp_ready);

  assign rsp_valid  = {(r_state == ALU_ARB_RESP) &&  r_own,
                       (r_state == ALU_ARB_RESP) && !r_own};
  assign rsp_result = r_result;
  assign rsp_err    = r_err;

  assign w_aluc = w_sel ? req_aluc1  : req_aluc0;
  assign w_num1 = w_sel ? req_num1_1 : req_num1_0;
  assign w_num2 = w_sel ? req_num2_1 : req_num2_0;

  alu_op_eval #(
    .BitWidth  (BitWidth),
    .AlucWidth (AlucWidth)
  ) u_op_eval (
    .i_aluc    (w_aluc),
    .i_num1    (w_num1),
    .i_num2    (w_num2),
    .o_result  (w_eval_result),
    .o_illegal (w_eval_illegal)
  );

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ALU_ARB_IDLE;
      r_prio   <= 1'b0;
      r_own    <= 1'b0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_state  <= ALU_ARB_RESP;
      r_own    <= w_sel;
      r_prio   <= ~w_sel;
      r_result <= w_eval_result;
      r_err    <= w_eval_illegal;
    end else if (w_rsp_hs) begin
      r_state <= ALU_ARB_IDLE;
    end
  end

`ifdef ALU_ARB_ABORT_EN
  always_ff @(posedge clk) begin
    if (rst_n && w_accept && w_eval_illegal) begin
      $fatal(1, "ebreak code=%0d pc=0x%08h unit=%0d", ABORT, 32'hdeafbeaf, UNIT_ALU);
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter: latency, arbitration, back-pressure,
// illegal opcodes and asynchronous reset.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic                clk;
  logic                rst_n;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [ALUC_BUS-1:0] req_aluc0;
  logic [ALUC_BUS-1:0] req_aluc1;
  logic [31:0]         req_num1_0;
  logic [31:0]         req_num2_0;
  logic [31:0]         req_num1_1;
  logic [31:0]         req_num2_1;
  logic [1:0]          rsp_valid;
  logic [1:0]          rsp_ready;
  logic [31:0]         rsp_result;
  logic                rsp_err;

  int n_checks = 0;
  int n_errors = 0;

  alu_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_aluc0  (req_aluc0),
    .req_aluc1  (req_aluc1),
    .req_num1_0 (req_num1_0),
    .req_num2_0 (req_num2_0),
    .req_num1_1 (req_num1_1),
    .req_num2_1 (req_num2_1),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  initial begin
    logic [1:0]  exp_own;
    logic [1:0]  prev_own;
    logic [31:0] prev_res;

    rst_n      = 1'b0;
    req_valid  = 2'b00;
    rsp_ready  = 2'b00;
    req_aluc0  = '0;
    req_aluc1  = '0;
    req_num1_0 = '0;
    req_num2_0 = '0;
    req_num1_1 = '0;
    req_num2_1 = '0;
    prev_own   = 2'b00;
    prev_res   = '0;

    repeat (2) @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_result",    rsp_result,     32'd0);
    check("rst_err",       32'(rsp_err),   32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;

    // Port 0 alone: ADD 5+7, one-cycle latency.
    @(negedge clk);
    rsp_ready = 2'b11; req_valid = 2'b01;
    req_aluc0 = ALUC_ADD; req_num1_0 = 32'd5; req_num2_0 = 32'd7;
    #1 check("add_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    #1 check("add_rsp_valid", 32'(rsp_valid), 32'd1);
    check("add_result", rsp_result, 32'd12);
    check("add_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    #1 check("add_idle", 32'(rsp_valid), 32'd0);

    // Both ports from reset: P0 SUB first, P1 ADD_JALR accepted on P0's handshake.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    req_valid = 2'b11;
    req_aluc0 = ALUC_SUB;      req_num1_0 = 32'd3;      req_num2_0 = 32'd5;
    req_aluc1 = ALUC_ADD_JALR; req_num1_1 = 32'h1001;   req_num2_1 = 32'h2;
    #1 check("both_req_ready0", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 2'b10;
    #1 check("sub_rsp_valid", 32'(rsp_valid), 32'd1);
    check("sub_result", rsp_result, 32'hFFFF_FFFE);
    check("jalr_req_ready", 32'(req_ready), 32'd2);
    @(negedge clk);
    req_valid = 2'b00;
    #1 check("jalr_rsp_valid", 32'(rsp_valid), 32'd2);
    check("jalr_result", rsp_result, 32'h1002);
    check("jalr_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    #1 check("jalr_idle", 32'(rsp_valid), 32'd0);

    // Back-pressure: P0 holds rsp_ready low for 4 cycles, its operands change meanwhile.
    @(negedge clk);
    rsp_ready = 2'b00; req_valid = 2'b11;
    req_aluc0 = ALUC_ADD; req_num1_0 = 32'd100; req_num2_0 = 32'd23;
    req_aluc1 = ALUC_ADD; req_num1_1 = 32'd1;   req_num2_1 = 32'd1;
    #1 check("stall_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 2'b10; req_num1_0 = 32'd999;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("stall%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
      check($sformatf("stall%0d_result", i),    rsp_result,     32'd123);
      check($sformatf("stall%0d_req_ready", i), 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 2'b11;
    #1 check("release_req_ready", 32'(req_ready), 32'd2);
    @(negedge clk);
    req_valid = 2'b00;
    #1 check("release_rsp_valid", 32'(rsp_valid), 32'd2);
    check("release_result", rsp_result, 32'd2);
    @(negedge clk);
    #1 check("release_idle", 32'(rsp_valid), 32'd0);

    // Illegal opcode on port 1.
    @(negedge clk);
    req_valid = 2'b10; req_aluc1 = 4'hF; req_num1_1 = 32'd7; req_num2_1 = 32'd8;
    #1 check("ill_req_ready", 32'(req_ready), 32'd2);
    @(negedge clk);
    req_valid = 2'b00;
    #1 check("ill_rsp_valid", 32'(rsp_valid), 32'd2);
    check("ill_result", rsp_result, 32'd0);
    check("ill_err", 32'(rsp_err), 32'd1);
    @(negedge clk);
    #1 check("ill_idle", 32'(rsp_valid), 32'd0);

    // Ten back-to-back operations with both ports always valid: grants alternate from port 0.
    req_aluc0 = ALUC_ADD; req_aluc1 = ALUC_SUB;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      req_valid  = 2'b11;
      req_num1_0 = 32'(k);  req_num2_0 = 32'd10;
      req_num1_1 = 32'd100; req_num2_1 = 32'(k);
      exp_own = k[0] ? 2'b10 : 2'b01;
      #1;
      if (k > 0) begin
        check($sformatf("rr%0d_rsp_valid", k - 1), 32'(rsp_valid), 32'(prev_own));
        check($sformatf("rr%0d_result", k - 1),    rsp_result,     prev_res);
      end
      check($sformatf("rr%0d_req_ready", k), 32'(req_ready), 32'(exp_own));
      prev_own = exp_own;
      prev_res = k[0] ? 32'(100 - k) : 32'(k + 10);
    end
    @(negedge clk);
    req_valid = 2'b00;
    #1 check("rr9_rsp_valid", 32'(rsp_valid), 32'(prev_own));
    check("rr9_result", rsp_result, prev_res);
    @(negedge clk);
    #1 check("rr_idle", 32'(rsp_valid), 32'd0);

    // Reset while a result is held (prio is 1 at that point); prio must return to 0.
    @(negedge clk);
    rsp_ready = 2'b00; req_valid = 2'b01;
    req_aluc0 = ALUC_ADD; req_num1_0 = 32'd1; req_num2_0 = 32'd2;
    #1 check("pre_rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    #1 check("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
    check("pre_rst_result", rsp_result, 32'd3);
    #1 rst_n = 1'b0;
    #1 check("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("async_rst_result", rsp_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; req_valid = 2'b11; rsp_ready = 2'b11;
    #1 check("post_rst_grant", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
